// File: rtl/psram_wb_pkg.sv
// Shared definitions for the asynchronous PSRAM Wishbone bridge:
// controller state encoding and default timing constants.
package psram_wb_pkg;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_ACK     = 3'd3,
    ST_RECOVER = 3'd4
  } state_t;

  localparam int PSRAM_INIT_CYCLES     = 7500;  // 150 us at 50 MHz
  localparam int PSRAM_ACCESS_CYCLES   = 4;
  localparam int PSRAM_RECOVERY_CYCLES = 1;

endpackage

// File: rtl/psram_wb.sv
// Wishbone classic slave driving an asynchronous-mode PSRAM; one halfword
// per access, with power-up wait, fixed strobe width and inter-access gap.
module psram_wb
  import psram_wb_pkg::*;
#(
  parameter int INIT_CYCLES     = PSRAM_INIT_CYCLES,
  parameter int ACCESS_CYCLES   = PSRAM_ACCESS_CYCLES,
  parameter int RECOVERY_CYCLES = PSRAM_RECOVERY_CYCLES
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic [31:0] wb_adr_i,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic [22:0] mem_addr,
  output logic        mem_clk,
  output logic        mem_cre,
  output logic        mem_ce_n,
  output logic        mem_oe_n,
  output logic        mem_we_n,
  output logic        mem_adv_n,
  output logic        mem_ub_n,
  output logic        mem_lb_n,
  output logic [15:0] mem_data_o,
  input  logic [15:0] mem_data_i,
  output logic        mem_data_oe
);

  localparam logic [15:0] INIT_LAST     = 16'(INIT_CYCLES - 1);
  localparam logic [3:0]  ACCESS_LAST   = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0]  RECOVERY_LAST = 4'(RECOVERY_CYCLES - 1);

  state_t      state_reg;
  logic [15:0] init_cnt_reg;
  logic [3:0]  cnt_reg;
  logic        we_reg;

  // The PSRAM only sees halfword addresses below 16 MB.
  logic unused_adr_bits;
  assign unused_adr_bits = ^{wb_adr_i[31:24], wb_adr_i[0]};

  assign mem_clk = 1'b0;
  assign mem_cre = 1'b0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= ST_INIT;
      init_cnt_reg <= '0;
      cnt_reg      <= '0;
      we_reg       <= 1'b0;
      wb_ack_o     <= 1'b0;
      wb_dat_o     <= '0;
      mem_addr     <= '0;
      mem_data_o   <= '0;
      mem_data_oe  <= 1'b0;
      mem_ce_n     <= 1'b1;
      mem_oe_n     <= 1'b1;
      mem_we_n     <= 1'b1;
      mem_adv_n    <= 1'b1;
      mem_ub_n     <= 1'b1;
      mem_lb_n     <= 1'b1;
    end else begin
      wb_ack_o <= 1'b0;
      case (state_reg)
        ST_INIT: begin
          // Counts elapsed power-up cycles; requests simply wait here.
          if (init_cnt_reg == INIT_LAST) begin
            state_reg <= ST_IDLE;
          end else begin
            init_cnt_reg <= init_cnt_reg + 16'd1;
          end
        end

        ST_IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            if (wb_sel_i != 2'b00) begin
              mem_addr    <= wb_adr_i[23:1];
              mem_data_o  <= wb_dat_i;
              we_reg      <= wb_we_i;
              cnt_reg     <= ACCESS_LAST;
              state_reg   <= ST_ACCESS;
              mem_ce_n    <= 1'b0;
              mem_adv_n   <= 1'b0;
              mem_ub_n    <= ~wb_sel_i[1];
              mem_lb_n    <= ~wb_sel_i[0];
              mem_oe_n    <= wb_we_i;
              mem_we_n    <= ~wb_we_i;
              mem_data_oe <= wb_we_i;
            end else begin
              // No lanes selected: acknowledge without touching the chip.
              wb_ack_o  <= 1'b1;
              state_reg <= ST_ACK;
            end
          end
        end

        ST_ACCESS: begin
          if (cnt_reg == 4'd0) begin
            if (!we_reg) begin
              wb_dat_o <= mem_data_i;
            end
            // A master that abandoned the cycle gets no ack, but the
            // PSRAM strobe has still run its full width.
            wb_ack_o    <= wb_cyc_i & wb_stb_i;
            state_reg   <= ST_ACK;
            mem_ce_n    <= 1'b1;
            mem_oe_n    <= 1'b1;
            mem_we_n    <= 1'b1;
            mem_adv_n   <= 1'b1;
            mem_ub_n    <= 1'b1;
            mem_lb_n    <= 1'b1;
            mem_data_oe <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end

        ST_ACK: begin
          if (RECOVERY_CYCLES == 0) begin
            state_reg <= ST_IDLE;
          end else begin
            cnt_reg   <= RECOVERY_LAST;
            state_reg <= ST_RECOVER;
          end
        end

        ST_RECOVER: begin
          if (cnt_reg == 4'd0) begin
            state_reg <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end

        default: state_reg <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_psram_wb.sv
// Directed bench for psram_wb with a behavioural PSRAM and a read-data
// scoreboard; latency is counted in clock edges from driving the request.
module tb_psram_wb;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic [31:0] wb_adr_i;
  logic [1:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_ack_o;
  logic [22:0] mem_addr;
  logic        mem_clk, mem_cre;
  logic        mem_ce_n, mem_oe_n, mem_we_n, mem_adv_n, mem_ub_n, mem_lb_n;
  logic [15:0] mem_data_o;
  logic [15:0] mem_data_i;
  logic        mem_data_oe;

  psram_wb #(
    .INIT_CYCLES(8),
    .ACCESS_CYCLES(4),
    .RECOVERY_CYCLES(1)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_adr_i(wb_adr_i),
    .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i),
    .wb_stb_i(wb_stb_i), .wb_ack_o(wb_ack_o),
    .mem_addr(mem_addr), .mem_clk(mem_clk), .mem_cre(mem_cre),
    .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
    .mem_adv_n(mem_adv_n), .mem_ub_n(mem_ub_n), .mem_lb_n(mem_lb_n),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_data_oe(mem_data_oe)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural PSRAM: 256 halfwords, byte-lane writes, async read.
  logic [15:0] pmem [0:255];
  logic        model_clear;

  always @(posedge clk_i) begin
    if (model_clear) begin
      for (int i = 0; i < 256; i++) pmem[i] <= 16'h1000 + 16'(i);
    end else if (!mem_ce_n && !mem_we_n) begin
      if (!mem_lb_n) pmem[mem_addr[7:0]][7:0]  <= mem_data_o[7:0];
      if (!mem_ub_n) pmem[mem_addr[7:0]][15:8] <= mem_data_o[15:8];
    end
  end

  assign mem_data_i = (!mem_ce_n && !mem_oe_n) ? pmem[mem_addr[7:0]] : 16'hDEAD;

  logic [15:0] shadow [0:255];
  logic [15:0] sb_q [$];
  logic [15:0] last_rd;
  int chk_cnt = 0;
  int pass_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i); #1;
    end
  endtask

  // One Wishbone transfer; collects per-cycle PSRAM pin statistics.
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [15:0] dat,
                      input logic [1:0] sel, input int abort_at,
                      output int lat, output int ce_first, output int ce_cyc,
                      output int we_cyc, output int lb_cyc, output int ub_cyc,
                      output int doe_cyc, output int dat_bad, output logic [22:0] addr_seen);
    logic [7:0]  a;
    logic [15:0] exp_rd;
    a = adr[8:1];
    lat = 0; ce_first = 0; ce_cyc = 0; we_cyc = 0; lb_cyc = 0; ub_cyc = 0;
    doe_cyc = 0; dat_bad = 0; addr_seen = '0;
    if (we && abort_at == 0) begin
      if (sel[0]) shadow[a][7:0]  = dat[7:0];
      if (sel[1]) shadow[a][15:8] = dat[15:8];
    end else if (!we && abort_at == 0) begin
      exp_rd = (sel == 2'b00) ? last_rd : shadow[a];
      sb_q.push_back(exp_rd);
      last_rd = exp_rd;
    end
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk_i); #1;
      if (i == 2) wb_dat_i = ~dat;
      if (!mem_ce_n) begin
        ce_cyc++;
        if (ce_first == 0) ce_first = i;
        addr_seen = mem_addr;
        if (we && mem_data_o !== dat) dat_bad++;
      end
      if (!mem_we_n) we_cyc++;
      if (!mem_lb_n) lb_cyc++;
      if (!mem_ub_n) ub_cyc++;
      if (mem_data_oe) doe_cyc++;
      if (wb_ack_o) begin
        lat = i;
        if (!we && sb_q.size() > 0) check("rd_data", 32'(wb_dat_o), 32'(sb_q.pop_front()));
        break;
      end
      if (i == abort_at) begin
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      end
      if (abort_at > 0 && i >= 12) break;
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    $display("xfer we=%0b adr=%h sel=%b abort_at=%0d lat=%0d ce_cyc=%0d dat_o=%h",
             we, adr, sel, abort_at, lat, ce_cyc, wb_dat_o);
  endtask

  int lat, ce_first, ce_cyc, we_cyc, lb_cyc, ub_cyc, doe_cyc, dat_bad, acks;
  logic [22:0] addr_seen;

  initial begin
    rst_i = 1'b1; model_clear = 1'b1;
    wb_dat_i = '0; wb_adr_i = '0; wb_sel_i = '0; wb_we_i = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    last_rd = '0;
    for (int i = 0; i < 256; i++) shadow[i] = 16'h1000 + 16'(i);
    idle(2);
    check("rst_ctrl_n", 32'({mem_ce_n, mem_oe_n, mem_we_n, mem_adv_n, mem_ub_n, mem_lb_n}), 32'h3F);
    check("rst_ack_oe", 32'({wb_ack_o, mem_data_oe, mem_clk, mem_cre}), 32'h0);
    check("rst_dat_o", 32'(wb_dat_o), 32'h0);
    check("rst_addr_data", {9'(mem_addr), mem_data_o}, 32'h0);
    rst_i = 1'b0; model_clear = 1'b0;

    // Power-up: request issued immediately, must wait out INIT.
    xfer(1'b0, 32'h0, 16'h0, 2'b11, 0, lat, ce_first, ce_cyc, we_cyc, lb_cyc, ub_cyc, doe_cyc, dat_bad, addr_seen);
    check("pwr_ce_first", 32'(ce_first), 32'd9);
    check("pwr_lat", 32'(lat), 32'd13);
    check("pwr_ce_cyc", 32'(ce_cyc), 32'd4);
    idle(2);

    xfer(1'b1, 32'h0000_0124, 16'hBEEF, 2'b11, 0, lat, ce_first, ce_cyc, we_cyc, lb_cyc, ub_cyc, doe_cyc, dat_bad, addr_seen);
    check("wr_lat", 32'(lat), 32'd5);
    check("wr_addr", 32'(addr_seen), 32'h92);
    check("wr_we_cyc", 32'(we_cyc), 32'd4);
    check("wr_doe_cyc", 32'(doe_cyc), 32'd4);
    check("wr_data_hold", 32'(dat_bad), 32'd0);
    idle(2);

    xfer(1'b0, 32'h0000_0124, 16'h0, 2'b11, 0, lat, ce_first, ce_cyc, we_cyc, lb_cyc, ub_cyc, doe_cyc, dat_bad, addr_seen);
    check("rd_lat", 32'(lat), 32'd5);
    check("rd_doe_cyc", 32'(doe_cyc), 32'd0);
    idle(2);

    xfer(1'b1, 32'h0000_0124, 16'h1234, 2'b01, 0, lat, ce_first, ce_cyc, we_cyc, lb_cyc, ub_cyc, doe_cyc, dat_bad, addr_seen);
    check("bw_lb_cyc", 32'(lb_cyc), 32'd4);
    check("bw_ub_cyc", 32'(ub_cyc), 32'd0);
    idle(2);

    xfer(1'b1, 32'h0000_0010, 16'hAB00, 2'b10, 0, lat, ce_first, ce_cyc, we_cyc, lb_cyc, ub_cyc, doe_cyc, dat_bad, addr_seen);
    check("uw_addr", 32'(addr_seen), 32'h8);
    check("uw_lanes", 32'({8'(lb_cyc), 8'(ub_cyc)}), 32'h0004);
    idle(2);

    // Back-to-back reads: the second request is driven right after ack.
    xfer(1'b0, 32'h0000_0124, 16'h0, 2'b11, 0, lat, ce_first, ce_cyc, we_cyc, lb_cyc, ub_cyc, doe_cyc, dat_bad, addr_seen);
    xfer(1'b0, 32'h0000_0010, 16'h0, 2'b11, 0, lat, ce_first, ce_cyc, we_cyc, lb_cyc, ub_cyc, doe_cyc, dat_bad, addr_seen);
    check("b2b_ce_first", 32'(ce_first), 32'd3);
    check("b2b_lat", 32'(lat), 32'd7);
    idle(2);

    // Abort: cyc dropped during ACCESS.
    xfer(1'b0, 32'h0000_0020, 16'h0, 2'b11, 2, lat, ce_first, ce_cyc, we_cyc, lb_cyc, ub_cyc, doe_cyc, dat_bad, addr_seen);
    check("abort_no_ack", 32'(lat), 32'd0);
    check("abort_ce_cyc", 32'(ce_cyc), 32'd4);
    idle(2);

    // Reset in the middle of an access.
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h40; wb_sel_i = 2'b11;
    idle(2);
    check("mid_ce_low", 32'(mem_ce_n), 32'd0);
    rst_i = 1'b1;
    idle(1);
    check("mid_rst_ctrl_n", 32'({mem_ce_n, mem_oe_n, mem_we_n, mem_adv_n, mem_ub_n, mem_lb_n, mem_data_oe}), 32'h7E);
    rst_i = 1'b0;
    acks = 0;
    for (int i = 0; i < 7; i++) begin
      if (wb_ack_o || !mem_ce_n) acks++;
      idle(1);
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    check("mid_rst_stall", 32'(acks), 32'd0);
    $display("xfer reset-mid-access adr=00000040 acks=%0d", acks);
    last_rd = '0;
    idle(1);

    xfer(1'b0, 32'h0000_0124, 16'h0, 2'b11, 0, lat, ce_first, ce_cyc, we_cyc, lb_cyc, ub_cyc, doe_cyc, dat_bad, addr_seen);
    check("post_rst_lat", 32'(lat), 32'd5);
    idle(2);

    xfer(1'b0, 32'h0, 16'h0, 2'b00, 0, lat, ce_first, ce_cyc, we_cyc, lb_cyc, ub_cyc, doe_cyc, dat_bad, addr_seen);
    check("sel0_lat", 32'(lat), 32'd1);
    check("sel0_ce_cyc", 32'(ce_cyc), 32'd0);
    idle(2);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/psram_wb.md
PSRAM_WB -- requirements
Module: psram_wb

Interface
REQ-001 SHALL have parameter INIT_CYCLES, default 7500: clk_i cycles of power-up wait after reset (150 us at 50 MHz).
REQ-002 SHALL have parameter ACCESS_CYCLES, default 4: clk_i cycles that the chip enable and strobes stay asserted per access; legal range 1..15.
REQ-003 SHALL have parameter RECOVERY_CYCLES, default 1: idle clk_i cycles after each ack before the next request is accepted; legal range 0..15.
REQ-004 Ports, listed as name, direction, width, meaning:
  clk_i  in  1  single clock; all logic on the rising edge.
  rst_i  in  1  reset, synchronous, active-high.
  wb_dat_i  in  16  write data.
  wb_dat_o  out  16  read data, registered.
  wb_adr_i  in  32  byte address.
  wb_sel_i  in  2  byte lanes; [1]=upper, [0]=lower.
  wb_we_i  in  1  write enable.
  wb_cyc_i, wb_stb_i  in  1 each  Wishbone classic cycle and strobe.
  wb_ack_o  out  1  one-cycle acknowledge.
  mem_addr  out  23  halfword address.
  mem_clk, mem_cre  out  1 each  tied 0 (asynchronous mode).
  mem_ce_n, mem_oe_n, mem_we_n, mem_adv_n, mem_ub_n, mem_lb_n  out  1 each  active-low PSRAM controls.
  mem_data_o  out  16  data driven to the PSRAM.
  mem_data_i  in  16  data from the PSRAM.
  mem_data_oe  out  1  output enable; the top level builds the tristate.

Function
REQ-005 The state machine SHALL have states INIT, IDLE, ACCESS, ACK and RECOVER.
REQ-006 INIT: the block SHALL count down INIT_CYCLES cycles, then enter IDLE; requests received during INIT SHALL be stalled and never acknowledged.
REQ-007 IDLE, on wb_cyc_i & wb_stb_i with wb_sel_i != 0:
  - the block SHALL latch mem_addr = wb_adr_i[23:1], the write data, wb_sel_i and wb_we_i;
  - it SHALL load the counter with ACCESS_CYCLES-1 and enter ACCESS.
REQ-008 IDLE, on a request with wb_sel_i == 0: the block SHALL go straight to ACK with no PSRAM strobe and wb_dat_o unchanged.
REQ-009 ACCESS, signal levels:
  - mem_ce_n=0 and mem_adv_n=0;
  - mem_ub_n=~sel[1] and mem_lb_n=~sel[0];
  - read: mem_oe_n=0, mem_we_n=1, mem_data_oe=0;
  - write: mem_oe_n=1, mem_we_n=0, mem_data_oe=1.
REQ-010 In ACCESS the counter SHALL decrement each cycle; when it reaches 0 on a read, the block SHALL register mem_data_i into wb_dat_o; on counter 0 the block SHALL enter ACK.
REQ-011 ACK:
  - wb_ack_o=1 for exactly one cycle if wb_cyc_i & wb_stb_i are still high, otherwise 0 (aborted cycle, ack suppressed);
  - all mem_*_n outputs SHALL be 1 and mem_data_oe=0.
REQ-012 Leaving ACK, the block SHALL go to RECOVER for RECOVERY_CYCLES cycles, or straight to IDLE when RECOVERY_CYCLES=0.
REQ-013 In RECOVER, strobes SHALL be ignored and all controls deasserted.
REQ-014 Latency: with the request first sampled in IDLE at cycle N, ack SHALL occur at N+ACCESS_CYCLES+1 (N+5 by default); a sel==0 ack SHALL occur at N+1.
REQ-015 A master dropping wb_cyc_i during ACCESS SHALL NOT shorten the PSRAM cycle.
REQ-016 Outside ACCESS: mem_ce_n, mem_oe_n, mem_we_n, mem_adv_n, mem_ub_n and mem_lb_n SHALL be 1, and mem_data_oe SHALL be 0.
REQ-017 mem_data_o SHALL hold the latched write data; it SHALL NOT follow wb_dat_i during ACCESS.

Reset
REQ-018 rst_i SHALL take effect on the next rising edge from any state, including mid-ACCESS, and SHALL move the block to INIT.
REQ-019 Reset values:
  - wb_ack_o=0, wb_dat_o=0, mem_addr=0, mem_data_o=0, mem_data_oe=0;
  - all mem_*_n outputs=1;
  - mem_clk=0 and mem_cre=0;
  - counters cleared.
REQ-020 A reset during ACCESS SHALL produce no ack, and the interrupted transaction SHALL be lost.

Structure
REQ-021 The state encodings and the default timing constants (INIT_CYCLES, ACCESS_CYCLES, RECOVERY_CYCLES) SHALL live in the shared SoC definitions package.
REQ-022 The module SHALL be a single module with no sub-module; the INIT counter SHALL be 16-bit and the access/recovery counter 4-bit.

Verification
REQ-023 Power-up: INIT_CYCLES=8, read request issued at cycle 0 after reset -> no ack and mem_ce_n=1 until INIT ends; then ack 5 cycles after acceptance.
REQ-024 Write then read:
  - write 0xBEEF, sel=2'b11, to byte address 0x0000_0124 -> mem_addr=0x92, mem_we_n=0 for 4 cycles, mem_data_o=0xBEEF;
  - PSRAM model later returns 0xBEEF on a read -> wb_dat_o=0xBEEF with the ack.
REQ-025 Byte write: sel=2'b01 -> mem_lb_n=0, mem_ub_n=1 throughout ACCESS; the model updates only the lower byte.
REQ-026 Back-to-back: the master holds stb after ack and issues a second read -> second access starts no earlier than 2 cycles after the first ack (RECOVERY_CYCLES=1).
REQ-027 Abort and reset:
  - cyc dropped in cycle 2 of ACCESS -> strobes stay for the full 4 cycles and no ack;
  - rst_i asserted mid-ACCESS -> next cycle all mem_*_n=1, state INIT, no ack.
REQ-028 sel==0 request -> ack at N+1, mem_ce_n held at 1, wb_dat_o unchanged.
